// File: rtl/lfsr_share_arb.sv
// -----------------------------------------------------------------------------
// lfsr_share_arb
//
// Purpose:
//   Shares one 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, shift left) among
//   NUM_REQ requesters with round-robin arbitration. Every grant hands the
//   winner the current LFSR word and advances the LFSR by exactly one step.
//   Supports runtime reseeding and pulses `wrap` when the state returns to
//   the most recently loaded seed.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   SEED     reset / default-reload LFSR value (must be nonzero)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   req        in   [NUM_REQ] level requests, held until the gnt bit is seen
//   gnt        out  [NUM_REQ] registered one-hot grant pulse
//   rnd_data   out  [16] random word for the granted requester
//   rnd_valid  out  high exactly when any gnt bit is high
//   seed_load  in   load seed_in into the LFSR (priority over requests)
//   seed_in    in   [16] new seed value (0 selects SEED)
//   wrap       out  pulse when the post-step state equals the last loaded seed
//   busy       out  high during the single LOAD cycle
//   lockup     out  (only with LFSR_SHARE_ARB_LOCKUP_DET_EN) pulse when an
//                   all-zero LFSR state was detected and SEED reloaded
//
// Optional feature macro: LFSR_SHARE_ARB_LOCKUP_DET_EN
// -----------------------------------------------------------------------------
module lfsr_share_arb #(
  parameter int          NUM_REQ = 4,
  parameter logic [15:0] SEED    = 16'h1001
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [15:0]        rnd_data,
  output logic               rnd_valid,
  input  logic               seed_load,
  input  logic [15:0]        seed_in,
  output logic               wrap,
  output logic               busy
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
  ,
  output logic               lockup
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t             r_state;
  logic [15:0]        r_lfsr;
  logic [15:0]        r_seed;        // last loaded seed, reference for wrap
  logic [15:0]        r_cnt;         // steps since last load / wrap
  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [15:0]        r_rnd_data;
  logic               r_rnd_valid;
  logic               r_wrap;
  logic               r_busy;
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
  logic               r_lockup;
`endif

  logic [NUM_REQ-1:0] w_elig;
  logic [PTR_W-1:0]   w_cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] w_cand_hit;
  logic               w_any;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [15:0]        w_lfsr_next;
  logic [15:0]        w_seed_sel;

  // A requester whose grant is visible this cycle is masked, so it can drop
  // req on its gnt cycle without being granted twice.
  assign w_elig = req & ~r_gnt;

  // Candidate gi is the requester gi positions above the pointer (mod NUM_REQ).
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [PTR_W:0] w_sum;
    assign w_sum = {1'b0, r_ptr} + (PTR_W+1)'(gi);
    assign w_cand_idx[gi] = (w_sum >= (PTR_W+1)'(NUM_REQ))
                          ? PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ))
                          : PTR_W'(w_sum);
    assign w_cand_hit[gi] = w_elig[w_cand_idx[gi]];
  end

  // Lowest candidate offset wins; scanning downward leaves the first hit last.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_cand_hit[i]) begin
        w_any = 1'b1;
        w_win = w_cand_idx[i];
      end
    end
  end

  always_comb begin
    w_win_onehot        = '0;
    w_win_onehot[w_win] = 1'b1;
  end

  assign w_ptr_next  = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  // A zero seed would lock the LFSR, so it is replaced by SEED.
  assign w_seed_sel  = (seed_in == 16'h0000) ? SEED : seed_in;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_lfsr      <= SEED;
      r_seed      <= SEED;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_rnd_data  <= '0;
      r_rnd_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_busy      <= 1'b0;
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
      r_lockup    <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; rnd_data holds between grants.
      r_gnt       <= '0;
      r_rnd_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_busy      <= 1'b0;
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
      r_lockup    <= 1'b0;
`endif
      if (seed_load) begin
        r_state <= LOAD;
        r_busy  <= 1'b1;
        r_lfsr  <= w_seed_sel;
        r_seed  <= w_seed_sel;
        r_cnt   <= '0;
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
      end else if (r_lfsr == 16'h0000) begin
        // Corrupted all-zero state: recover instead of granting zeros forever.
        r_state  <= IDLE;
        r_lfsr   <= SEED;
        r_seed   <= SEED;
        r_cnt    <= '0;
        r_lockup <= 1'b1;
`endif
      end else begin
        case (r_state)
          IDLE:    r_state <= w_any ? RUN : IDLE;
          RUN:     r_state <= w_any ? RUN : IDLE;
          LOAD:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
        // Arbitration also runs in the LOAD cycle so pending requests are
        // granted on the edge right after busy.
        if (w_any) begin
          r_gnt       <= w_win_onehot;
          r_rnd_valid <= 1'b1;
          r_rnd_data  <= r_lfsr;
          r_lfsr      <= w_lfsr_next;
          r_ptr       <= w_ptr_next;
          if (w_lfsr_next == r_seed) begin
            r_wrap <= 1'b1;
            r_cnt  <= '0;
          end else begin
            r_cnt  <= r_cnt + 16'd1;
          end
        end
      end
    end
  end

  assign gnt       = r_gnt;
  assign rnd_data  = r_rnd_data;
  assign rnd_valid = r_rnd_valid;
  assign wrap      = r_wrap;
  assign busy      = r_busy;
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
  assign lockup    = r_lockup;
`endif

endmodule

// File: tb/tb_lfsr_share_arb.sv
// -----------------------------------------------------------------------------
// tb_lfsr_share_arb
//
// Directed self-checking bench for lfsr_share_arb (NUM_REQ=4, SEED=0x1001).
// Covers reset values, single-requester alternation, four-way rotation,
// reseeding (including zero-seed substitution), reset during a grant,
// optional lockup recovery, and the full-period wrap pulse.
// -----------------------------------------------------------------------------
module tb_lfsr_share_arb;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [15:0] rnd_data;
  logic        rnd_valid;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        wrap;
  logic        busy;
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
  logic        lockup;
`endif

  int errors = 0;
  int checks = 0;

  lfsr_share_arb #(
    .NUM_REQ (4),
    .SEED    (16'h1001)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .wrap      (wrap),
    .busy      (busy)
`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
    ,
    .lockup    (lockup)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] seq_a [5];
  logic [3:0]  rot   [5];
  logic [15:0] m;
  int grants, wraps, wrap_at, bad_data, stray, cyc;

  initial begin
    seq_a[0] = 16'h1001; seq_a[1] = 16'h2003; seq_a[2] = 16'h4007;
    seq_a[3] = 16'h800E; seq_a[4] = 16'h001D;
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100;
    rot[3] = 4'b1000; rot[4] = 4'b0001;

    reset_n   = 1'b0;
    req       = 4'b0000;
    seed_load = 1'b0;
    seed_in   = 16'h0000;

    // ---- reset values ----
    tick; tick;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_valid", rnd_valid, 1'b0);
    check("rst_data", rnd_data, 16'h0000);
    check("rst_wrap", wrap, 1'b0);
    check("rst_busy", busy, 1'b0);
    $display("txn reset: gnt=%b valid=%b data=%h", gnt, rnd_valid, rnd_data);

    // ---- single requester: grant every other cycle ----
    reset_n = 1'b1;
    req     = 4'b0001;
    tick;
    for (int i = 0; i < 5; i++) begin
      check("single_gnt", gnt, 4'b0001);
      check("single_valid", rnd_valid, 1'b1);
      check("single_data", rnd_data, seq_a[i]);
      $display("txn single grant %0d: gnt=%b data=%h", i, gnt, rnd_data);
      if (i < 4) begin
        tick;
        check("single_gap_gnt", gnt, 4'b0000);
        check("single_gap_valid", rnd_valid, 1'b0);
        check("single_gap_hold", rnd_data, seq_a[i]);
        tick;
      end
    end
    req = 4'b0000;
    tick;
    check("single_idle_gnt", gnt, 4'b0000);

    // ---- four requesters from the cycle after reset ----
    reset_n = 1'b0;
    tick; tick;
    reset_n = 1'b1;
    req     = 4'b1111;
    tick;
    for (int i = 0; i < 5; i++) begin
      check("rot_gnt", gnt, rot[i]);
      check("rot_valid", rnd_valid, 1'b1);
      check("rot_data", rnd_data, seq_a[i]);
      $display("txn rotate %0d: gnt=%b data=%h", i, gnt, rnd_data);
      if (i < 4) tick;
    end

    // ---- reseed with 0xACE1 while all request ----
    seed_load = 1'b1;
    seed_in   = 16'hACE1;
    tick;
    seed_load = 1'b0;
    check("load_busy", busy, 1'b1);
    check("load_gnt", gnt, 4'b0000);
    check("load_valid", rnd_valid, 1'b0);
    check("load_hold", rnd_data, 16'h001D);
    $display("txn seed_load ACE1: busy=%b gnt=%b", busy, gnt);
    tick;
    check("post_load_busy", busy, 1'b0);
    check("post_load_gnt", gnt, 4'b0010);
    check("post_load_data", rnd_data, 16'hACE1);
    $display("txn after load: gnt=%b data=%h", gnt, rnd_data);
    tick;
    check("post_load2_gnt", gnt, 4'b0100);
    check("post_load2_data", rnd_data, 16'h59C3);
    $display("txn after load 2: gnt=%b data=%h", gnt, rnd_data);

    // ---- reseed with zero: SEED is substituted ----
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    tick;
    seed_load = 1'b0;
    check("zload_busy", busy, 1'b1);
    check("zload_gnt", gnt, 4'b0000);
    tick;
    check("zload_gnt1", gnt, 4'b1000);
    check("zload_data1", rnd_data, 16'h1001);
    $display("txn zero-seed load: gnt=%b data=%h", gnt, rnd_data);
    tick;
    check("zload_gnt2", gnt, 4'b0001);
    check("zload_data2", rnd_data, 16'h2003);
    $display("txn zero-seed next: gnt=%b data=%h", gnt, rnd_data);

    // ---- reset while a grant is visible ----
    reset_n = 1'b0;
    tick;
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_valid", rnd_valid, 1'b0);
    check("midrst_data", rnd_data, 16'h0000);
    $display("txn reset mid-grant: gnt=%b valid=%b", gnt, rnd_valid);
    reset_n = 1'b1;
    req     = 4'b0000;
    tick;
    check("idle_static_gnt", gnt, 4'b0000);

`ifdef LFSR_SHARE_ARB_LOCKUP_DET_EN
    // ---- all-zero state recovery ----
    force dut.r_lfsr = 16'h0000;
    #1;
    release dut.r_lfsr;
    req = 4'b0001;
    tick;
    check("lockup_pulse", lockup, 1'b1);
    check("lockup_gnt", gnt, 4'b0000);
    tick;
    check("lockup_clear", lockup, 1'b0);
    check("lockup_next_gnt", gnt, 4'b0001);
    check("lockup_next_data", rnd_data, 16'h1001);
    $display("txn lockup recovery: gnt=%b data=%h", gnt, rnd_data);
    req = 4'b0000;
    tick;
`endif

    // ---- full period: two requesters give one grant per cycle ----
    seed_load = 1'b1;
    seed_in   = 16'h1001;
    tick;
    seed_load = 1'b0;
    check("period_load_busy", busy, 1'b1);
    req      = 4'b0011;
    m        = 16'h1001;
    grants   = 0;
    wraps    = 0;
    wrap_at  = 0;
    bad_data = 0;
    stray    = 0;
    cyc      = 0;
    while (grants < 65537 && cyc < 70000) begin
      tick;
      cyc++;
      if (rnd_valid) begin
        grants++;
        if (rnd_data !== m) bad_data++;
        m = lfsr_step(m);
        if (wrap) begin
          wraps++;
          if (wraps == 1) wrap_at = grants;
          if (m !== 16'h1001) bad_data++;
        end
      end else if (wrap) begin
        stray++;
      end
    end
    req = 4'b0000;
    check("period_grants", grants, 32'd65537);
    check("period_data_errs", bad_data, 32'd0);
    check("period_wraps", wraps, 32'd1);
    check("period_wrap_at", wrap_at, 32'd65535);
    check("period_stray_wrap", stray, 32'd0);
    $display("txn full period: grants=%0d wraps=%0d wrap_at=%0d", grants, wraps, wrap_at);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
